alu_result_stage: RTL and testbench
===================================

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the datapath width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have ports res_and, res_or, res_xor, res_add, each input, WIDTH, the unit results from the bitwise and adder units.
REQ-005 The block SHALL have port add_cout, input, 1, adder carry-out.
REQ-006 The block SHALL have port sel, input, 3, the operation select.
REQ-007 The block SHALL have port in_valid, input, 1, the upstream result-present flag.
REQ-008 The block SHALL have port in_ready, output, 1, high when an entry can be accepted.
REQ-009 The block SHALL have port out_valid, output, 1, high when the head entry is presented.
REQ-010 The block SHALL have port out_ready, input, 1, the downstream accept signal.
REQ-011 The block SHALL have port out_data, output, WIDTH, the head result.
REQ-012 The block SHALL have ports out_zero, out_cout and out_err, each output, 1, the head flags.

Function
REQ-013 sel encoding SHALL be: 000 AND→res_and; 001 OR→res_or; 010 ADD→res_add; 011 XOR→res_xor; 110 SUB→res_add; 111 SLT→{WIDTH-1 zeros, res_add[WIDTH-1]}.
REQ-014 Codes 100 and 101 SHALL produce data 0 with err=1; all legal codes SHALL produce err=0.
REQ-015 The cout flag SHALL equal add_cout for codes ADD and SUB, and 0 otherwise.
REQ-016 The zero flag SHALL be 1 exactly when the selected data equals 0, computed before storage.
REQ-017 Storage SHALL be a 2-entry FIFO of {data, zero, cout, err} with a registered count of 0..2.
REQ-018 in_ready SHALL equal (count != 2); a push SHALL occur when in_valid && in_ready.
REQ-019 A pop SHALL occur when out_valid && out_ready; out_valid SHALL equal (count != 0).
REQ-020 Latency: an entry pushed in cycle N into an empty FIFO SHALL appear on the outputs in cycle N+1.
REQ-021 On a simultaneous push and pop at count 1, count SHALL stay 1 and the pushed entry SHALL become the head in the next cycle.
REQ-022 At count 2 no push SHALL occur; a pop SHALL reduce count to 1 and promote the second entry.
REQ-023 While out_valid=1 and out_ready=0, the outputs SHALL hold stable.
REQ-024 At count 0, out_data and all flags SHALL read 0.
REQ-025 in_valid without in_ready SHALL have no effect; upstream SHALL hold its data until accepted.

Reset
REQ-026 Asserting rst SHALL immediately force count=0, out_valid=0, out_data=0 and all flags to 0, while in_ready SHALL read 1.
REQ-027 Reset asserted mid-operation SHALL discard all stored entries; the first push after deassertion SHALL behave as into an empty FIFO.

Structure
REQ-028 The sel codes and the default WIDTH SHALL live in shared package alu_pkg.
REQ-029 Operation selection and flag generation SHALL be a combinational sub-module named alu_result_mux; the top SHALL contain only the FIFO and handshake.

Verification
REQ-030 With sel=011, res_xor=0xFFFF0000 and in_valid for 1 cycle with out_ready=1, the bench SHALL see out_data=0xFFFF0000 and zero=0 in the next cycle, then out_valid=0.
REQ-031 With sel=111 and res_add=0x80000001, the bench SHALL see out_data=0x00000001; with sel=010, res_add=0 and add_cout=1, it SHALL see zero=1 and cout=1.
REQ-032 With out_ready=0, pushing 0x1 then 0x2 SHALL give in_ready=0 at count 2 and a third push ignored; raising out_ready SHALL pop 0x1 then 0x2 in order.
REQ-033 At count 1 with head 0xA, a push of 0xB with a concurrent pop SHALL present 0xB next cycle with count 1.
REQ-034 With sel=100, the bench SHALL see out_data=0 and err=1.
REQ-035 Asserting rst with count=2 SHALL give out_valid=0 and in_ready=1 before the next clk edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage.
//   DEFAULT_WIDTH : default datapath width
//   alu_op_e      : operation select encoding carried on sel
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_XOR  = 3'b011,
    OP_RSV4 = 3'b100,
    OP_RSV5 = 3'b101,
    OP_SUB  = 3'b110,
    OP_SLT  = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_result_mux.sv
// Combinational result select and flag generation.
//   sel                          : operation select (alu_op_e)
//   res_and/or/xor/add, add_cout : unit results
//   data, zero, cout, err        : selected result and its flags
module alu_result_mux
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] res_and,
  input  logic [WIDTH-1:0] res_or,
  input  logic [WIDTH-1:0] res_xor,
  input  logic [WIDTH-1:0] res_add,
  input  logic             add_cout,
  output logic [WIDTH-1:0] data,
  output logic             zero,
  output logic             cout,
  output logic             err
);

  always_comb begin
    data = '0;
    cout = 1'b0;
    err  = 1'b0;
    case (alu_op_e'(sel))
      OP_AND: data = res_and;
      OP_OR:  data = res_or;
      OP_XOR: data = res_xor;
      OP_ADD: begin data = res_add; cout = add_cout; end
      OP_SUB: begin data = res_add; cout = add_cout; end
      // SLT: the subtract result's sign bit is the less-than answer
      OP_SLT: data = {{(WIDTH-1){1'b0}}, res_add[WIDTH-1]};
      default: err = 1'b1;  // reserved codes 100/101
    endcase
  end

  assign zero = (data == '0);

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: selects a unit result, tags it with flags and buffers
// it in a 2-entry valid/ready FIFO.
//   clk, rst                      : clock, async active-high reset
//   res_*, add_cout, sel          : unit results and operation select
//   in_valid / in_ready           : upstream handshake
//   out_valid / out_ready         : downstream handshake
//   out_data, out_zero/cout/err   : head entry (all zero when empty)
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] res_and,
  input  logic [WIDTH-1:0] res_or,
  input  logic [WIDTH-1:0] res_xor,
  input  logic [WIDTH-1:0] res_add,
  input  logic             add_cout,
  input  logic [2:0]       sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_cout,
  output logic             out_err
);

  // entry layout: {data, zero, cout, err}
  localparam int EW = WIDTH + 3;

  logic [WIDTH-1:0] mux_data;
  logic             mux_zero, mux_cout, mux_err;

  alu_result_mux #(.WIDTH(WIDTH)) u_mux (
    .sel      (sel),
    .res_and  (res_and),
    .res_or   (res_or),
    .res_xor  (res_xor),
    .res_add  (res_add),
    .add_cout (add_cout),
    .data     (mux_data),
    .zero     (mux_zero),
    .cout     (mux_cout),
    .err      (mux_err)
  );

  // slot 0 is always the head; slot 1 is the second entry
  logic [EW-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          push, pop;
  logic [EW-1:0] new_ent;

  assign new_ent   = {mux_data, mux_zero, mux_cout, mux_err};
  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    if (push && pop) begin
      // only reachable at count 1: new entry replaces the departing head
      ent0_d = new_ent;
    end else if (pop) begin
      ent0_d = ent1_q;
      cnt_d  = cnt_q - 2'd1;
    end else if (push) begin
      if (cnt_q == 2'd0) ent0_d = new_ent;
      else               ent1_d = new_ent;
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  // gate on out_valid so an empty FIFO reads zero whatever slot 0 holds
  assign {out_data, out_zero, out_cout, out_err} = out_valid ? ent0_q : '0;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] res_and, res_or, res_xor, res_add;
  logic         add_cout;
  logic [2:0]   sel;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] out_data;
  logic         out_zero, out_cout, out_err;

  alu_result_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .res_and(res_and), .res_or(res_or), .res_xor(res_xor), .res_add(res_add),
    .add_cout(add_cout), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero), .out_cout(out_cout), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: queue of {data, zero, cout, err}
  logic [W+2:0] q[$];

  function automatic logic [W+2:0] model_op(input logic [2:0] s, input logic [W-1:0] a,
      input logic [W-1:0] o, input logic [W-1:0] x, input logic [W-1:0] sm, input logic c);
    logic [W-1:0] d;
    logic co, er;
    d = 0; co = 0; er = 0;
    case (s)
      3'd0: d = a;
      3'd1: d = o;
      3'd2: begin d = sm; co = c; end
      3'd3: d = x;
      3'd6: begin d = sm; co = c; end
      3'd7: d = (sm >= 32'h8000_0000) ? 1 : 0;   // signed result negative
      default: er = 1;
    endcase
    return {d, (d == 0), co, er};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // compare all outputs with the model
  task automatic chk_model(input string tag);
    logic [W+2:0] e;
    e = (q.size() != 0) ? q[0] : '0;
    chk({tag, " valid"}, 64'(out_valid), 64'(q.size() != 0));
    chk({tag, " ready"}, 64'(in_ready), 64'(q.size() != 2));
    chk({tag, " entry"}, 64'({out_data, out_zero, out_cout, out_err}), 64'(e));
  endtask

  // apply one cycle: inputs held over the next posedge, model stepped,
  // then outputs checked at the following negedge
  task automatic drive(input logic iv, input logic ordy, input string tag);
    logic push, pop;
    logic [W+2:0] e;
    in_valid = iv; out_ready = ordy;
    push = iv && (q.size() != 2);
    pop  = (q.size() != 0) && ordy;
    e = model_op(sel, res_and, res_or, res_xor, res_add, add_cout);
    @(posedge clk);
    if (!rst) begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(e);
    end
    @(negedge clk); #1;
    chk_model(tag);
  endtask

  task automatic set_in(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] o,
      input logic [W-1:0] x, input logic [W-1:0] sm, input logic c);
    sel = s; res_and = a; res_or = o; res_xor = x; res_add = sm; add_cout = c;
  endtask

  typedef struct {
    logic [2:0]   s;
    logic [W-1:0] a, o, x, sm;
    logic         c;
    logic [W-1:0] ed;
    logic         ez, ec, ee;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{3'b000, 32'h0F0F_00F0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1'b1, 32'h0F0F_00F0, 0, 0, 0};
    tbl[1]  = '{3'b001, 32'h0F0F_00F0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1'b1, 32'h1111_1111, 0, 0, 0};
    tbl[2]  = '{3'b010, 32'h0F0F_00F0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1'b1, 32'h3333_3333, 0, 1, 0};
    tbl[3]  = '{3'b011, 32'h0F0F_00F0, 32'h1111_1111, 32'hFFFF_0000, 32'h3333_3333, 1'b1, 32'hFFFF_0000, 0, 0, 0};
    tbl[4]  = '{3'b110, 32'h5, 32'h6, 32'h7, 32'h0, 1'b1, 32'h0, 1, 1, 0};
    tbl[5]  = '{3'b111, 32'h5, 32'h6, 32'h7, 32'h8000_0001, 1'b1, 32'h1, 0, 0, 0};
    tbl[6]  = '{3'b111, 32'h5, 32'h6, 32'h7, 32'h7FFF_FFFF, 1'b1, 32'h0, 1, 0, 0};
    tbl[7]  = '{3'b100, 32'h5, 32'h6, 32'h7, 32'h8, 1'b1, 32'h0, 1, 0, 1};
    tbl[8]  = '{3'b101, 32'h5, 32'h6, 32'h7, 32'h8, 1'b1, 32'h0, 1, 0, 1};
    tbl[9]  = '{3'b010, 32'h5, 32'h6, 32'h7, 32'h0, 1'b1, 32'h0, 1, 1, 0};
    tbl[10] = '{3'b000, 32'h0, 32'hFFFF_FFFF, 32'h7, 32'h8, 1'b0, 32'h0, 1, 0, 0};
    tbl[11] = '{3'b011, 32'h1, 32'h2, 32'h0, 32'h8, 1'b1, 32'h0, 1, 0, 0};

    rst = 1; in_valid = 0; out_ready = 0;
    set_in(3'b000, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0; #1;
    chk("reset valid", 64'(out_valid), 64'(0));
    chk("reset ready", 64'(in_ready), 64'(1));
    chk("reset entry", 64'({out_data, out_zero, out_cout, out_err}), 64'(0));

    // table vectors: push into empty FIFO, visible next cycle, then drained
    foreach (tbl[i]) begin
      set_in(tbl[i].s, tbl[i].a, tbl[i].o, tbl[i].x, tbl[i].sm, tbl[i].c);
      drive(1, 1, "tbl push");
      chk($sformatf("tbl%0d out", i), 64'({out_valid, out_data, out_zero, out_cout, out_err}),
          64'({1'b1, tbl[i].ed, tbl[i].ez, tbl[i].ec, tbl[i].ee}));
      drive(0, 1, "tbl drain");
      chk($sformatf("tbl%0d empty", i), 64'(out_valid), 64'(0));
    end

    // fill to 2 with out_ready low, third push ignored, drain in order
    set_in(3'b001, 0, 32'h1, 0, 0, 0); drive(1, 0, "fill1");
    set_in(3'b001, 0, 32'h2, 0, 0, 0); drive(1, 0, "fill2");
    chk("full ready", 64'(in_ready), 64'(0));
    set_in(3'b001, 0, 32'h3, 0, 0, 0); drive(1, 0, "fill3");
    chk("full hold", 64'(out_data), 64'(32'h1));
    in_valid = 0;
    drive(0, 1, "pop1");
    chk("pop order 2", 64'(out_data), 64'(32'h2));
    drive(0, 1, "pop2");
    chk("pop empty", 64'(out_valid), 64'(0));

    // push and pop together at count 1
    set_in(3'b001, 0, 32'hA, 0, 0, 0); drive(1, 0, "headA");
    chk("headA", 64'(out_data), 64'(32'hA));
    set_in(3'b001, 0, 32'hB, 0, 0, 0); drive(1, 1, "swapB");
    chk("swap head B", 64'({out_valid, in_ready, out_data}), 64'({1'b1, 1'b1, 32'hB}));
    drive(0, 1, "swap drain");
    chk("swap count1", 64'(out_valid), 64'(0));

    // asynchronous reset with a full FIFO
    set_in(3'b001, 0, 32'h11, 0, 0, 0); drive(1, 0, "rf1");
    set_in(3'b001, 0, 32'h22, 0, 0, 0); drive(1, 0, "rf2");
    rst = 1; #1;
    chk("async rst valid", 64'(out_valid), 64'(0));
    chk("async rst ready", 64'(in_ready), 64'(1));
    chk("async rst data", 64'({out_data, out_zero, out_cout, out_err}), 64'(0));
    q.delete();
    drive(0, 0, "in rst");
    rst = 0;
    set_in(3'b011, 0, 0, 32'h55, 0, 0); drive(1, 0, "post rst push");
    chk("post rst head", 64'(out_data), 64'(32'h55));
    drive(0, 1, "post rst drain");

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] r[4];
      for (int k = 0; k < 4; k++) r[k] = ($urandom_range(0, 5) == 0) ? '0 : $urandom;
      set_in(3'($urandom_range(0, 7)), r[0], r[1], r[2], r[3], 1'($urandom));
      drive(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
